// File: rtl/riesgos_pkg.sv
// Shared types and constants for the control_riesgos hazard sequencer.
package riesgos_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int REG_W = 4;

  // Encoding placed in a pipeline register when it is cleared to a NOP (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter: clr restarts the count (at 1 if en is also set),
// en increments and the value sticks at all-ones.
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: restart, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = en ? W'(1) : '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/control_riesgos.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and memory-wait freeze.
// Optional PERF_CNT_EN builds the saturating stall/flush performance counters.
module control_riesgos #(
  parameter int REG_W       = riesgos_pkg::REG_W,
  parameter int FLUSH_CYC   = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Ra_Dec,
  input  logic             RE_A_Dec,
  input  logic [REG_W-1:0] Rb_Dec,
  input  logic             RE_B_Dec,
  input  logic [REG_W-1:0] Robj_Reg_Exe,
  input  logic             WE_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken_Exe,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_PC,
  output logic             stall_Dec,
  output logic             flush_Dec,
  output logic             bubble_Exe,
  output logic             freeze_all,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import riesgos_pkg::*;

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FC_INIT  = FC_W'(FLUSH_CYC - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  state_e          act_s;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            mem_error_q, mem_error_d;
  logic [TO_W-1:0] to_cnt_s;
  logic            to_clr_s, to_en_s;
  logic            lu_s, pend_s;
  logic            stall_pc_s, stall_dec_s, flush_dec_s, bubble_exe_s, freeze_all_s;

  assign lu_s = mem_RE_Reg_Exe & WE_Reg_Exe &
                ((RE_A_Dec & (Ra_Dec == Robj_Reg_Exe)) |
                 (RE_B_Dec & (Rb_Dec == Robj_Reg_Exe)));
  assign pend_s = mem_req & ~mem_ack;

  // The ack cycle of a memory wait is decoded as the state it returns to.
  always_comb begin
    act_s = state_q;
    if ((state_q == ST_MEM_WAIT) && mem_ack) begin
      act_s = ret_q;
    end else begin
      act_s = state_q;
    end
  end

  // Next state and hazard outputs; memory wait outranks flush, flush outranks load-use.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    fcnt_d       = fcnt_q;
    mem_error_d  = mem_error_q;
    to_clr_s     = 1'b1;
    to_en_s      = 1'b0;
    stall_pc_s   = 1'b0;
    stall_dec_s  = 1'b0;
    flush_dec_s  = 1'b0;
    bubble_exe_s = 1'b0;
    freeze_all_s = 1'b0;
    case (act_s)
      ST_RUN: begin
        if (pend_s) begin
          freeze_all_s = 1'b1;
          state_d      = ST_MEM_WAIT;
          ret_d        = ST_RUN;
          to_en_s      = 1'b1;
        end else if (branch_taken_Exe) begin
          flush_dec_s  = 1'b1;
          bubble_exe_s = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_INIT;
          end else begin
            state_d = ST_RUN;
            fcnt_d  = '0;
          end
        end else if (lu_s) begin
          stall_pc_s   = 1'b1;
          stall_dec_s  = 1'b1;
          bubble_exe_s = 1'b1;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (pend_s) begin
          freeze_all_s = 1'b1;
          state_d      = ST_MEM_WAIT;
          ret_d        = ST_FLUSH;
          to_en_s      = 1'b1;
        end else begin
          flush_dec_s  = 1'b1;
          bubble_exe_s = 1'b1;
          if (fcnt_q <= FC_W'(1)) begin
            state_d = ST_RUN;
            fcnt_d  = '0;
          end else begin
            state_d = ST_FLUSH;
            fcnt_d  = fcnt_q - FC_W'(1);
          end
        end
      end
      ST_MEM_WAIT: begin
        to_clr_s = 1'b0;
        if (to_cnt_s >= TO_LIMIT) begin
          mem_error_d = 1'b1;
          state_d     = ST_RUN;
          fcnt_d      = '0;
        end else begin
          freeze_all_s = 1'b1;
          to_en_s      = 1'b1;
          state_d      = ST_MEM_WAIT;
        end
      end
      default: begin
        state_d = ST_RUN;
        ret_d   = ST_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      fcnt_q      <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      fcnt_q      <= fcnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  contador_sat #(.W(TO_W)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (to_clr_s),
    .en    (to_en_s),
    .cnt   (to_cnt_s)
  );

  assign stall_PC   = stall_pc_s   & ~reset;
  assign stall_Dec  = stall_dec_s  & ~reset;
  assign flush_Dec  = flush_dec_s  & ~reset;
  assign bubble_Exe = bubble_exe_s & ~reset;
  assign freeze_all = freeze_all_s & ~reset;
  assign mem_error  = mem_error_q  & ~reset;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_s, flush_cnt_s;

  contador_sat #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (stall_PC | freeze_all),
    .cnt   (stall_cnt_s)
  );

  contador_sat #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (flush_Dec),
    .cnt   (flush_cnt_s)
  );

  assign stall_cnt = reset ? '0 : stall_cnt_s;
  assign flush_cnt = reset ? '0 : flush_cnt_s;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_control_riesgos.sv
// Self-checking bench for control_riesgos: directed hazard scenarios followed by
// random traffic, all compared against an event-level reference model.
module tb_control_riesgos;

  localparam int REG_W       = 4;
  localparam int FLUSH_CYC   = 2;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [REG_W-1:0] Ra_Dec, Rb_Dec, Robj_Reg_Exe;
  logic             RE_A_Dec, RE_B_Dec, WE_Reg_Exe, mem_RE_Reg_Exe;
  logic             branch_taken_Exe, mem_req, mem_ack;
  logic             stall_PC, stall_Dec, flush_Dec, bubble_Exe, freeze_all, mem_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  control_riesgos #(
    .REG_W(REG_W), .FLUSH_CYC(FLUSH_CYC), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .Ra_Dec(Ra_Dec), .RE_A_Dec(RE_A_Dec), .Rb_Dec(Rb_Dec), .RE_B_Dec(RE_B_Dec),
    .Robj_Reg_Exe(Robj_Reg_Exe), .WE_Reg_Exe(WE_Reg_Exe), .mem_RE_Reg_Exe(mem_RE_Reg_Exe),
    .branch_taken_Exe(branch_taken_Exe), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_PC(stall_PC), .stall_Dec(stall_Dec), .flush_Dec(flush_Dec),
    .bubble_Exe(bubble_Exe), .freeze_all(freeze_all), .mem_error(mem_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owed flush cycles, wait progress, error flag, event counts.
  int flush_left, waited, s_cnt, f_cnt;
  bit waiting, err;
  int nx_flush_left, nx_waited, nx_scnt, nx_fcnt;
  bit nx_waiting, nx_err;
  bit e_spc, e_sdec, e_fl, e_bub, e_frz, e_merr;
  int e_scnt, e_fcnt;
  bit obs_spc, obs_fl, obs_frz, obs_merr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    bit lu, pend, decode;
    lu = mem_RE_Reg_Exe && WE_Reg_Exe &&
         ((RE_A_Dec && (Ra_Dec == Robj_Reg_Exe)) || (RE_B_Dec && (Rb_Dec == Robj_Reg_Exe)));
    pend = mem_req && !mem_ack;
    {e_spc, e_sdec, e_fl, e_bub, e_frz} = '0;
    nx_flush_left = flush_left; nx_waiting = waiting; nx_waited = waited; nx_err = err;
    decode = 1'b1;
    if (reset) begin
      nx_flush_left = 0; nx_waiting = 0; nx_waited = 0; nx_err = 0; decode = 0;
    end else if (waiting) begin
      if (mem_ack) nx_waiting = 0;
      else if (waited >= MEM_TIMEOUT) begin
        nx_err = 1; nx_waiting = 0; nx_flush_left = 0; decode = 0;
      end else begin
        e_frz = 1; nx_waited = waited + 1; decode = 0;
      end
    end
    if (decode) begin
      if (pend) begin
        e_frz = 1; nx_waiting = 1; nx_waited = 1;
      end else if (flush_left > 0) begin
        e_fl = 1; e_bub = 1; nx_flush_left = flush_left - 1;
      end else if (branch_taken_Exe) begin
        e_fl = 1; e_bub = 1; nx_flush_left = FLUSH_CYC - 1;
      end else if (lu) begin
        e_spc = 1; e_sdec = 1; e_bub = 1;
      end
    end
    e_merr = reset ? 1'b0 : err;
    if (reset) begin
      e_scnt = 0; e_fcnt = 0; nx_scnt = 0; nx_fcnt = 0;
    end else begin
      e_scnt = s_cnt; e_fcnt = f_cnt;
      nx_scnt = ((e_spc || e_frz) && s_cnt < CNT_MAX) ? s_cnt + 1 : s_cnt;
      nx_fcnt = (e_fl && f_cnt < CNT_MAX) ? f_cnt + 1 : f_cnt;
    end
  endtask

  // Inputs are already set (just after a falling edge); check, then clock once.
  task automatic tick();
    #1;
    model_eval();
    obs_spc = stall_PC; obs_fl = flush_Dec; obs_frz = freeze_all; obs_merr = mem_error;
    check("stall_PC",   32'(stall_PC),   32'(e_spc));
    check("stall_Dec",  32'(stall_Dec),  32'(e_sdec));
    check("flush_Dec",  32'(flush_Dec),  32'(e_fl));
    check("bubble_Exe", 32'(bubble_Exe), 32'(e_bub));
    check("freeze_all", 32'(freeze_all), 32'(e_frz));
    check("mem_error",  32'(mem_error),  32'(e_merr));
    check("stall_cnt",  32'(stall_cnt),  PERF ? 32'(e_scnt) : 32'd0);
    check("flush_cnt",  32'(flush_cnt),  PERF ? 32'(e_fcnt) : 32'd0);
    @(posedge clk);
    flush_left = nx_flush_left; waiting = nx_waiting; waited = nx_waited; err = nx_err;
    s_cnt = nx_scnt; f_cnt = nx_fcnt;
    @(negedge clk);
  endtask

  task automatic idle();
    Ra_Dec = '0; Rb_Dec = '0; Robj_Reg_Exe = '0;
    RE_A_Dec = 1'b0; RE_B_Dec = 1'b0; WE_Reg_Exe = 1'b0; mem_RE_Reg_Exe = 1'b0;
    branch_taken_Exe = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic load_r3_in_exe();
    idle();
    Robj_Reg_Exe = 4'd3; WE_Reg_Exe = 1'b1; mem_RE_Reg_Exe = 1'b1;
  endtask

  int n;

  initial begin
    flush_left = 0; waited = 0; s_cnt = 0; f_cnt = 0; waiting = 0; err = 0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    // Hazard-looking inputs during reset must not reach the outputs.
    load_r3_in_exe(); Ra_Dec = 4'd3; RE_A_Dec = 1'b1; branch_taken_Exe = 1'b1;
    tick();
    mem_req = 1'b1;
    tick();
    reset = 1'b0; idle();
    tick();

    // Load-use on source A: one stall cycle, then clear once EXE holds the bubble.
    load_r3_in_exe(); Ra_Dec = 4'd3; RE_A_Dec = 1'b1;
    tick(); check("s1_stall", 32'(obs_spc), 32'd1);
    idle(); tick(); check("s1_after", 32'(obs_spc), 32'd0);

    // Unread source and non-load producer: no stall.
    load_r3_in_exe(); Ra_Dec = 4'd3; RE_A_Dec = 1'b0; Rb_Dec = 4'd5; RE_B_Dec = 1'b1;
    tick(); check("s2_unread", 32'(obs_spc), 32'd0);
    load_r3_in_exe(); mem_RE_Reg_Exe = 1'b0; Ra_Dec = 4'd3; RE_A_Dec = 1'b1;
    tick(); check("s2_nonload", 32'(obs_spc), 32'd0);
    load_r3_in_exe(); Rb_Dec = 4'd3; RE_B_Dec = 1'b1;
    tick(); check("s2_srcb", 32'(obs_spc), 32'd1);

    // Taken branch, second branch in the flush window ignored.
    n = 0;
    idle(); branch_taken_Exe = 1'b1; tick(); n += int'(obs_fl);
    tick(); n += int'(obs_fl);
    idle(); tick(); n += int'(obs_fl);
    check("s3_flush_cycles", 32'(n), 32'd2);

    // Memory wait with ack on the fourth cycle.
    n = 0;
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); n += int'(obs_frz); end
    mem_ack = 1'b1; tick(); check("s4_ack_frz", 32'(obs_frz), 32'd0);
    check("s4_freeze_cycles", 32'(n), 32'd3);
    idle(); tick();

    // Memory wait inside a flush resumes the remaining flush cycle.
    n = 0;
    idle(); branch_taken_Exe = 1'b1; tick(); n += int'(obs_fl);
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); n += int'(obs_fl); end
    mem_ack = 1'b1; tick(); n += int'(obs_fl);
    check("s4b_resume_flush", 32'(obs_fl), 32'd1);
    idle(); tick(); n += int'(obs_fl);
    check("s4b_flush_cycles", 32'(n), 32'd2);

    // Timeout: eight freeze cycles, then the sticky error and back to RUN.
    n = 0;
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 9; i++) begin tick(); n += int'(obs_frz); end
    check("s5_freeze_cycles", 32'(n), 32'd8);
    idle(); tick(); check("s5_error", 32'(obs_merr), 32'd1);
    tick(); check("s5_sticky", 32'(obs_merr), 32'd1);
    reset = 1'b1; tick();
    reset = 1'b0; tick(); check("s5_reset_clears", 32'(obs_merr), 32'd0);

    // One stall plus one branch flush after reset.
    load_r3_in_exe(); Ra_Dec = 4'd3; RE_A_Dec = 1'b1; tick();
    idle(); branch_taken_Exe = 1'b1; tick();
    idle(); tick();
`ifdef PERF_CNT_EN
    check("s6_stall_cnt", 32'(stall_cnt), 32'd1);
    check("s6_flush_cnt", 32'(flush_cnt), 32'd2);
`endif
    // Hold a load-use long enough to saturate the stall counter.
    load_r3_in_exe(); Ra_Dec = 4'd3; RE_A_Dec = 1'b1;
    for (int i = 0; i < CNT_MAX + 4; i++) tick();
    idle(); tick();
`ifdef PERF_CNT_EN
    check("s6_stall_sat", 32'(stall_cnt), 32'(CNT_MAX));
`endif

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      Ra_Dec           = REG_W'($urandom_range(0, 3));
      Rb_Dec           = REG_W'($urandom_range(0, 3));
      Robj_Reg_Exe     = REG_W'($urandom_range(0, 3));
      RE_A_Dec         = 1'($urandom_range(0, 1));
      RE_B_Dec         = 1'($urandom_range(0, 1));
      WE_Reg_Exe       = ($urandom_range(0, 3) != 0);
      mem_RE_Reg_Exe   = ($urandom_range(0, 2) == 0);
      branch_taken_Exe = ($urandom_range(0, 9) == 0);
      mem_req          = ($urandom_range(0, 4) == 0);
      mem_ack          = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
